// File: rtl/key_cond_pkg.sv
// Shared types and defaults for the push-button key conditioner.
// No logic of its own: the key FSM state encoding, key bit positions and default parameters.
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CNT   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CNT = 2'd3
  } key_state_t;

  localparam int KEY_RUN = 1;
  localparam int KEY_RLC = 0;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_SYNC_STAGES     = 2;

  // Counter width for the debounce window; one bit minimum so a window of 1 still elaborates.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser plus debounce FSM for one active-low key; registered level and press/release pulses.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES+1 edges from raw edge to output; no backpressure.
module key_debounce
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_lvl_n,
  output logic key_press,
  output logic key_release
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("key_debounce: SYNC_STAGES must be >= 2");
  end

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;
  key_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   key_lvl_n_q, key_lvl_n_d;
  logic                   key_press_q, key_press_d;
  logic                   key_release_q, key_release_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], key_n};
  assign sync   = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RELEASED: begin
        if (!sync) begin
          state_d = PRESS_CNT;
          cnt_d   = '0;
        end
      end
      PRESS_CNT: begin
        if (sync) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (sync) begin
          state_d = RELEASE_CNT;
          cnt_d   = '0;
        end
      end
      RELEASE_CNT: begin
        if (!sync) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  // Outputs are decoded from the next state so they land in the same edge as the transition.
  always_comb begin
    key_lvl_n_d   = !((state_d == PRESSED) || (state_d == RELEASE_CNT));
    key_press_d   = (state_q == PRESS_CNT) && (state_d == PRESSED);
    key_release_d = (state_q == RELEASE_CNT) && (state_d == RELEASED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= '1;
      state_q       <= RELEASED;
      cnt_q         <= '0;
      key_lvl_n_q   <= 1'b1;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_lvl_n_q   <= key_lvl_n_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  assign key_lvl_n   = key_lvl_n_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the Run/Reset_Load_Clear keys and slider switches feeding the multiplier; no backpressure.
// KEY_COND_SWITCH_SYNC_EN: S goes through a SYNC_STAGES flop chain, otherwise S = S_raw combinationally.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] Key_n,
  input  logic [7:0] S_raw,
  output logic [1:0] Key_lvl_n,
  output logic [1:0] Key_press,
  output logic [1:0] Key_release,
  output logic [7:0] S
);

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_key_run (
    .clk        (Clk),
    .reset      (Reset),
    .key_n      (Key_n[KEY_RUN]),
    .key_lvl_n  (Key_lvl_n[KEY_RUN]),
    .key_press  (Key_press[KEY_RUN]),
    .key_release(Key_release[KEY_RUN])
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_key_rlc (
    .clk        (Clk),
    .reset      (Reset),
    .key_n      (Key_n[KEY_RLC]),
    .key_lvl_n  (Key_lvl_n[KEY_RLC]),
    .key_press  (Key_press[KEY_RLC]),
    .key_release(Key_release[KEY_RLC])
  );

`ifdef KEY_COND_SWITCH_SYNC_EN
  // Switches are slow and glitch-tolerant downstream, so synchronise only, no debounce.
  logic [SYNC_STAGES-1:0][7:0] s_sync_q, s_sync_d;

  assign s_sync_d = {s_sync_q[SYNC_STAGES-2:0], S_raw};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s_sync_q <= '0;
    end else begin
      s_sync_q <= s_sync_d;
    end
  end

  assign S = s_sync_q[SYNC_STAGES-1];
`else
  assign S = S_raw;
`endif

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Input-conditioning stage directly upstream of the 8-bit multiplier datapath.
- Synchronises and debounces the two push-button keys (Run = KEY1, Reset_Load_Clear = KEY0), which are active-low.
- Outputs a clean active-low level per key, which drops straight into the multiplier's Run/Reset_Load_Clear inputs, plus single-cycle press/release pulses.
- Optionally synchronises the 8 slider switches that feed the multiplier's S operand.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronised key must stay stable before its change is accepted (10 ms at 50 MHz); must be >= 1.
- SYNC_STAGES, 2, depth of the metastability flop chain on every asynchronous input; must be >= 2.

Ports:
- Clk  input  1  system clock
- Reset  input  1  power-on reset, synchronous, active-high (not a key)
- Key_n  input  2  raw keys, active-low; [1]=Run, [0]=Reset_Load_Clear
- S_raw  input  8  raw slider switches
- Key_lvl_n  output  2  debounced key level, active-low, same bit mapping as Key_n
- Key_press  output  2  one-cycle active-high pulse on an accepted press
- Key_release  output  2  one-cycle active-high pulse on an accepted release
- S  output  8  switch value to the multiplier

Behaviour:
- One clock (Clk). Reset is synchronous and active-high; every flop samples it on posedge Clk.
- Reset values:
  - all key sync flops = 1
  - Key_lvl_n = 2'b11
  - Key_press = Key_release = 2'b00
  - every FSM = RELEASED, every counter = 0
  - S sync flops = 8'h00 (macro builds only)
- Each key has an independent per-key FSM. Counter width is clog2(DEBOUNCE_CYCLES). The FSM acts on sync = last stage of that key's chain.
  - RELEASED: if sync==0, go to PRESS_CNT and set cnt=0; otherwise stay.
  - PRESS_CNT:
    - if sync==1, go back to RELEASED (bounce rejected; no pulse).
    - else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED.
    - else cnt++.
  - PRESSED: if sync==1, go to RELEASE_CNT and set cnt=0.
  - RELEASE_CNT:
    - if sync==0, go back to PRESSED.
    - else if cnt==DEBOUNCE_CYCLES-1, go to RELEASED.
    - else cnt++.
- Outputs are registered:
  - Key_lvl_n[i]=0 exactly while the FSM is in PRESSED or RELEASE_CNT.
  - Key_press[i]=1 only in the first cycle of PRESSED when entered from PRESS_CNT.
  - Key_release[i]=1 only in the first cycle of RELEASED when entered from RELEASE_CNT.
- Latency:
  - Raw edge sampled at posedge 1 and held stable: the Key_lvl_n change and the pulse are visible after posedge SYNC_STAGES+DEBOUNCE_CYCLES+1.
  - With the default parameters this is 500003 edges; with test parameters (4, 2) it is 7 edges.
- Any instability inside a counting window restarts the full window. The counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Keys are fully independent. Simultaneous presses give pulses in the same cycle. Press and release pulses of one key are never high together.
- Reset mid-operation: the FSM and counters abort immediately; no pulse is emitted in or after the reset cycle.
- A key held low across reset deassertion is treated as a new press. Its pulse appears SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after the first non-reset edge.
- Parameter rules are enforced by elaboration-time assertions: DEBOUNCE_CYCLES==0 or SYNC_STAGES<2 is an error.

Optional Feature:
- Macro KEY_COND_SWITCH_SYNC_EN.
- Defined:
  - S_raw passes through a SYNC_STAGES-deep, 8-bit-wide flop chain, with reset value 8'h00.
  - S = last stage, with a latency of SYNC_STAGES edges.
  - No debounce on switches.
- Undefined:
  - S = S_raw combinationally; no switch flops exist.
  - S has no reset value.

Decomposition:
- Package key_cond_pkg holds:
  - key_state_t enum {RELEASED, PRESS_CNT, PRESSED, RELEASE_CNT}
  - localparams KEY_RUN=1, KEY_RLC=0
  - defaults DEF_DEBOUNCE_CYCLES=500000, DEF_SYNC_STAGES=2
- Sub-module key_debounce: one key, consisting of the sync chain, FSM, counter and the three registered outputs, with the same parameters. key_conditioner instantiates it twice and adds the switch path.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, macro defined unless noted):
- Reset: hold Reset 3 cycles with Key_n=2'b11 and S_raw=8'hFF -> Key_lvl_n=2'b11, Key_press=Key_release=0 and S=8'h00 while Reset is high; S=8'hFF 2 edges after release.
- Clean press/release: drive Key_n[1] 1->0 and hold -> Key_press[1]=1 for exactly one cycle and Key_lvl_n[1]=0, both after edge 7. Return to 1 -> Key_release[1] one-cycle pulse after edge 7; Key_press[1] never rises in between.
- Bounce: Key_n[0] low 3 cycles, high 1, low 2, high 1, then low held -> no pulse until 7 edges after the final falling edge, then exactly one Key_press[0].
- Simultaneous: Key_n 2'b11->2'b00 in one cycle -> Key_press=2'b11 in the same single cycle; Key_lvl_n=2'b00.
- Reset mid-count: assert Reset while key 1 is in PRESS_CNT (cnt=2) with the key held low -> no pulse and Key_lvl_n[1] stays 1 during reset; after Reset drops, Key_press[1] pulses 7 edges later.
- Switch path: S_raw=8'hA5 -> S=8'hA5 after 2 edges with the macro; with the macro undefined, S=8'hA5 in the same cycle.
